// File: rtl/proc_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : proc_mem_arbiter                                             |
// | Description : Round-robin merge of imem/dmem request streams onto a single |
// |               memory port; in-order responses steered back by a routing   |
// |               FIFO. Optional counters: PROC_MEM_ARBITER_STATS_EN.          |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module proc_mem_arbiter #(
  parameter int p_max_outst = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [76:0] req0_msg,
  input  logic        req0_val,
  output logic        req0_rdy,
  input  logic [76:0] req1_msg,
  input  logic        req1_val,
  output logic        req1_rdy,
  output logic [76:0] memreq_msg,
  output logic        memreq_val,
  input  logic        memreq_rdy,
  input  logic [46:0] memresp_msg,
  input  logic        memresp_val,
  output logic        memresp_rdy,
  output logic [46:0] resp0_msg,
  output logic        resp0_val,
  input  logic        resp0_rdy,
  output logic [46:0] resp1_msg,
  output logic        resp1_val,
  input  logic        resp1_rdy,
  output logic [31:0] stat_grant0,
  output logic [31:0] stat_grant1,
  output logic [31:0] stat_conflict
);

  localparam int            c_AW      = $clog2(p_max_outst);
  localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

  // Routing entry: {port_id, original opaque}
  logic [8:0]    r_fifo [p_max_outst];
  logic [c_AW:0] r_wr_ptr;
  logic [c_AW:0] r_rd_ptr;
  logic          r_prio;

  logic          w_full;
  logic          w_empty;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_xfer;
  logic          w_pop;
  logic [76:0]   w_sel_msg;
  logic [8:0]    w_head;

  assign w_full  = (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]) &&
                   (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // Gating with reset keeps every handshake output low while reset is held.
  assign w_grant1 = reset & req1_val & (~req0_val | r_prio);
  assign w_grant0 = reset & req0_val & ~w_grant1;

  assign w_sel_msg  = w_grant1 ? req1_msg : req0_msg;
  assign memreq_msg = {w_sel_msg[76:74], 7'b0, w_grant1, w_sel_msg[65:0]};
  assign memreq_val = (w_grant0 | w_grant1) & ~w_full;
  assign req0_rdy   = w_grant0 & memreq_rdy & ~w_full;
  assign req1_rdy   = w_grant1 & memreq_rdy & ~w_full;
  assign w_xfer     = memreq_val & memreq_rdy;

  assign w_head      = r_fifo[r_rd_ptr[c_AW-1:0]];
  assign resp0_val   = memresp_val & ~w_empty & ~w_head[8];
  assign resp1_val   = memresp_val & ~w_empty &  w_head[8];
  assign resp0_msg   = {memresp_msg[46:44], w_head[7:0], memresp_msg[35:0]};
  assign resp1_msg   = {memresp_msg[46:44], w_head[7:0], memresp_msg[35:0]};
  assign memresp_rdy = ~w_empty & (w_head[8] ? resp1_rdy : resp0_rdy);
  assign w_pop       = memresp_val & memresp_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_prio   <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
        r_prio   <= ~w_grant1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_fifo[r_wr_ptr[c_AW-1:0]] <= {w_grant1, w_sel_msg[73:66]};
    end
  end

`ifdef PROC_MEM_ARBITER_STATS_EN
  logic [31:0] r_stat_grant0;
  logic [31:0] r_stat_grant1;
  logic [31:0] r_stat_conflict;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stat_grant0   <= 32'd0;
      r_stat_grant1   <= 32'd0;
      r_stat_conflict <= 32'd0;
    end else begin
      if (w_xfer && w_grant0) r_stat_grant0 <= r_stat_grant0 + 32'd1;
      if (w_xfer && w_grant1) r_stat_grant1 <= r_stat_grant1 + 32'd1;
      if (req0_val && req1_val) r_stat_conflict <= r_stat_conflict + 32'd1;
    end
  end

  assign stat_grant0   = r_stat_grant0;
  assign stat_grant1   = r_stat_grant1;
  assign stat_conflict = r_stat_conflict;
`else
  assign stat_grant0   = 32'd0;
  assign stat_grant1   = 32'd0;
  assign stat_conflict = 32'd0;
`endif

endmodule
`default_nettype wire
